// File: rtl/pixel_frame_sequencer.sv
// pixel_frame_sequencer: erase/expose/convert/read frame controller with Gray ramp ADC and streamed binary pixel output
// Ports:
//   clk, reset (async active-low)
//   start, continuous, cfg_expose, abort     frame control
//   erase, expose, convert, ramp_code, read  pixel array drive
//   col_gray                                 Gray data of the selected row, column k at [k*B +: B]
//   out_data/out_valid/out_ready             pixel stream, with out_sof/out_eol/out_eof markers
//   busy                                     high outside IDLE
module pixel_frame_sequencer #(
  parameter int H = 4,
  parameter int W = 4,
  parameter int B = 8,
  parameter int C_ERASE = 5,
  parameter int C_READ = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           continuous,
  input  logic [15:0]    cfg_expose,
  input  logic           abort,
  output logic           erase,
  output logic           expose,
  output logic           convert,
  output logic [B-1:0]   ramp_code,
  output logic [H-1:0]   read,
  input  logic [W*B-1:0] col_gray,
  output logic [B-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_sof,
  output logic           out_eol,
  output logic           out_eof,
  output logic           busy
);
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ERASE   = 3'd1;
  localparam logic [2:0] S_EXPOSE  = 3'd2;
  localparam logic [2:0] S_CONVERT = 3'd3;
  localparam logic [2:0] S_READ    = 3'd4;
  localparam logic [2:0] S_STREAM  = 3'd5;
  localparam logic [15:0] ERASE_LAST = 16'(C_ERASE - 1);
  localparam logic [15:0] CONV_LAST  = 16'((1 << B) - 1);
  localparam logic [15:0] READ_LAST  = 16'(C_READ - 1);
  localparam logic [RW-1:0] R_LAST   = RW'(H - 1);
  localparam logic [CW-1:0] C_LAST   = CW'(W - 1);

  logic [2:0]            state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [15:0]           exp_q, exp_d;
  logic [15:0]           exp_last;
  logic [RW-1:0]         r_q, r_d;
  logic [CW-1:0]         c_q, c_d;
  logic [B-1:0]          ramp_q, ramp_d;
  logic [W-1:0][B-1:0]   buf_q, buf_d;
  logic                  xfer, last_col, last_row;

  function automatic logic [B-1:0] g2b(input logic [B-1:0] g);
    g2b[B-1] = g[B-1];
    for (int i = B - 2; i >= 0; i--) g2b[i] = g2b[i+1] ^ g[i];
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 16'd1;
    exp_d    = exp_q;
    r_d      = r_q;
    c_d      = c_q;
    buf_d    = buf_q;
    // a zero exposure setting still gives one expose cycle
    exp_last = (exp_q == 16'd0) ? 16'd0 : exp_q - 16'd1;
    xfer     = (state_q == S_STREAM) && out_ready;
    last_col = (c_q == C_LAST);
    last_row = (r_q == R_LAST);
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = S_ERASE;
          exp_d   = cfg_expose;
          r_d     = '0;
        end
      end
      S_ERASE: if (cnt_q == ERASE_LAST) begin
        state_d = S_EXPOSE;
        cnt_d   = '0;
      end
      S_EXPOSE: if (cnt_q == exp_last) begin
        state_d = S_CONVERT;
        cnt_d   = '0;
      end
      S_CONVERT: if (cnt_q == CONV_LAST) begin
        state_d = S_READ;
        cnt_d   = '0;
        r_d     = '0;
      end
      S_READ: if (cnt_q == READ_LAST) begin
        state_d = S_STREAM;
        cnt_d   = '0;
        c_d     = '0;
        for (int k = 0; k < W; k++) buf_d[k] = g2b(col_gray[k*B +: B]);
      end
      S_STREAM: begin
        cnt_d = '0;
        if (xfer) begin
          c_d = last_col ? '0 : c_q + 1'b1;
          if (last_col && !last_row) begin
            state_d = S_READ;
            r_d     = r_q + 1'b1;
          end else if (last_col) begin
            // continuous is looked at only here, so clearing it mid-frame finishes the frame
            state_d = continuous ? S_ERASE : S_IDLE;
            exp_d   = continuous ? cfg_expose : exp_q;
            r_d     = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      r_d     = '0;
      c_d     = '0;
    end
    // ramp is registered from the next-state counter so it lines up with convert
    ramp_d = (state_d == S_CONVERT) ? cnt_d[B-1:0] ^ (cnt_d[B-1:0] >> 1) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      exp_q   <= '0;
      r_q     <= '0;
      c_q     <= '0;
      ramp_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      r_q     <= r_d;
      c_q     <= c_d;
      ramp_q  <= ramp_d;
      buf_q   <= buf_d;
    end
  end

  assign erase     = (state_q == S_ERASE);
  assign expose    = (state_q == S_EXPOSE);
  assign convert   = (state_q == S_CONVERT);
  assign ramp_code = ramp_q;
  assign read      = (state_q == S_READ) ? H'(1) << r_q : '0;
  assign out_valid = (state_q == S_STREAM);
  assign out_data  = out_valid ? buf_q[c_q] : '0;
  assign out_sof   = out_valid && (r_q == '0) && (c_q == '0);
  assign out_eol   = out_valid && last_col;
  assign out_eof   = out_valid && last_col && last_row;
  assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// tb_pixel_frame_sequencer: directed self-checking bench for pixel_frame_sequencer (H=2, W=2, B=4, C_ERASE=3, C_READ=2)
// Ports: none; drives the DUT through clk/reset/start/continuous/cfg_expose/abort/out_ready and a two-row pixel array model
module tb_pixel_frame_sequencer;
  localparam int H = 2, W = 2, B = 4, CE = 3, CR = 2;
  localparam logic [7:0] ROW0 = {4'b0011, 4'b0110};
  localparam logic [7:0] ROW1 = {4'b1000, 4'b1111};
  localparam logic [3:0] GRAY_TAB [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                           4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
  // row0: col0 0110->4, col1 0011->2; row1: col0 1111->10, col1 1000->15
  localparam logic [3:0] PIX [4] = '{4'd4, 4'd2, 4'd10, 4'd15};

  logic clk = 0, reset = 0, start = 0, continuous = 0, abort = 0, out_ready = 0;
  logic [15:0] cfg_expose = 0;
  logic erase, expose, convert, out_valid, out_sof, out_eol, out_eof, busy;
  logic [B-1:0] ramp_code, out_data;
  logic [H-1:0] read;
  logic [W*B-1:0] col_gray;
  int vec = 0, miss = 0;
  logic [3:0] px [64];
  logic [2:0] mk [64];
  logic [3:0] rc [64];
  int n_er, n_ex, n_cv, n_px, n_busy, n_viol;

  assign col_gray = read[1] ? ROW1 : ROW0;
  always #5 clk = ~clk;

  pixel_frame_sequencer #(.H(H), .W(W), .B(B), .C_ERASE(CE), .C_READ(CR)) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous), .cfg_expose(cfg_expose),
    .abort(abort), .erase(erase), .expose(expose), .convert(convert), .ramp_code(ramp_code),
    .read(read), .col_gray(col_gray), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof), .busy(busy)
  );

  task automatic go(input logic [15:0] e);
    @(negedge clk);
    cfg_expose = e;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  // records one busy period; out_ready is set before sampling so it matches the coming edge
  task automatic capture(input bit stall, input bit cont);
    logic [7:0] prev = '0;
    bit prev_stall = 0;
    n_er = 0; n_ex = 0; n_cv = 0; n_px = 0; n_busy = 0; n_viol = 0;
    for (int k = 0; k < 3000; k++) begin
      out_ready = stall ? (k % 3 == 0) : 1'b1;
      if (cont) begin
        start = convert && (k % 7 == 3);
        if (n_cv == 36) continuous = 0;
      end
      if (!busy) break;
      n_busy++;
      if (erase) n_er++;
      if (expose) n_ex++;
      if (convert && n_cv < 64) rc[n_cv] = ramp_code;
      if (convert) n_cv++;
      if (!convert && ramp_code != 0) n_viol++;
      if (prev_stall && {out_valid, out_data, out_sof, out_eol, out_eof} !== prev) n_viol++;
      if (out_valid && out_ready && n_px < 64) begin
        px[n_px] = out_data;
        mk[n_px] = {out_sof, out_eol, out_eof};
        n_px++;
      end
      prev = {out_valid, out_data, out_sof, out_eol, out_eof};
      prev_stall = out_valid && !out_ready;
      @(negedge clk);
    end
    start = 0;
    out_ready = 0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    vec++;
    if ({erase, expose, convert, ramp_code, read, out_data, out_valid, out_sof, out_eol, out_eof, busy} !== '0) begin
      miss++; $display("FAIL reset_outputs: got %b want 0", {erase, expose, convert, ramp_code, read, out_data, out_valid, out_sof, out_eol, out_eof, busy});
    end
    reset = 1;
    repeat (3) @(negedge clk);
    vec++;
    if (busy !== 1'b0) begin miss++; $display("FAIL idle_after_reset: busy=%b want 0", busy); end
  endtask

  task automatic check_pixels(input string name, input int frames);
    vec++;
    if (n_px != 4 * frames) begin miss++; $display("FAIL %s_count: got %0d pixels want %0d", name, n_px, 4 * frames); end
    for (int i = 0; i < 4 * frames && i < n_px; i++) begin
      vec++;
      if ({px[i], mk[i]} !== {PIX[i%4], (i % 4) == 0, (i % 2) == 1, (i % 4) == 3}) begin
        miss++; $display("FAIL %s_pixel%0d: got data=%0d sof/eol/eof=%b want data=%0d sof/eol/eof=%b",
          name, i, px[i], mk[i], PIX[i%4], {(i % 4) == 0, (i % 2) == 1, (i % 4) == 3});
      end
    end
  endtask

  task automatic test_basic;
    go(16'd5);
    capture(0, 0);
    vec++;
    if ({n_er, n_ex, n_cv} !== {32'd3, 32'd5, 32'd16}) begin
      miss++; $display("FAIL basic_phases: erase=%0d expose=%0d convert=%0d want 3 5 16", n_er, n_ex, n_cv);
    end
    for (int i = 0; i < 16; i++) begin
      vec++;
      if (rc[i] !== GRAY_TAB[i]) begin miss++; $display("FAIL basic_ramp%0d: got %0d want %0d", i, rc[i], GRAY_TAB[i]); end
    end
    check_pixels("basic", 1);
    vec++;
    if (n_busy != CE + 5 + 16 + H * (CR + W)) begin miss++; $display("FAIL basic_length: got %0d want %0d", n_busy, CE + 5 + 16 + H * (CR + W)); end
    vec++;
    if (n_viol != 0 || busy !== 1'b0) begin miss++; $display("FAIL basic_end: violations=%0d busy=%b want 0 0", n_viol, busy); end
  endtask

  task automatic test_stall;
    go(16'd5);
    capture(1, 0);
    check_pixels("stall", 1);
    vec++;
    if (n_viol != 0) begin miss++; $display("FAIL stall_hold: got %0d unstable stalled cycles want 0", n_viol); end
    vec++;
    if (n_busy <= 32) begin miss++; $display("FAIL stall_length: got %0d cycles want >32", n_busy); end
  endtask

  task automatic test_expose;
    go(16'd4);
    cfg_expose = 16'd9;
    capture(0, 0);
    vec++;
    if ({n_ex, n_busy} !== {32'd4, 32'd31}) begin miss++; $display("FAIL expose_latched: expose=%0d len=%0d want 4 31", n_ex, n_busy); end
    go(16'd0);
    capture(0, 0);
    vec++;
    if ({n_ex, n_busy} !== {32'd1, 32'd28}) begin miss++; $display("FAIL expose_zero: expose=%0d len=%0d want 1 28", n_ex, n_busy); end
  endtask

  task automatic test_back_to_back;
    continuous = 1;
    go(16'd5);
    capture(0, 1);
    check_pixels("cont", 3);
    vec++;
    if ({n_busy, n_cv, n_ex} !== {32'd96, 32'd48, 32'd15}) begin
      miss++; $display("FAIL cont_length: busy=%0d convert=%0d expose=%0d want 96 48 15", n_busy, n_cv, n_ex);
    end
    repeat (2) @(negedge clk);
    vec++;
    if (busy !== 1'b0) begin miss++; $display("FAIL cont_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_abort;
    int t = 0;
    go(16'd5);
    out_ready = 1;
    while (read !== 2'b10 && t < 200) begin @(negedge clk); t++; end
    vec++;
    if (t >= 200) begin miss++; $display("FAIL abort_reach_read1: read=%b want 10 within 200 cycles", read); end
    abort = 1;
    @(negedge clk);
    abort = 0;
    vec++;
    if ({erase, expose, convert, ramp_code, read, out_data, out_valid, out_sof, out_eol, out_eof, busy} !== '0) begin
      miss++; $display("FAIL abort_outputs: got %b want 0", {erase, expose, convert, ramp_code, read, out_data, out_valid, out_sof, out_eol, out_eof, busy});
    end
    go(16'd5);
    capture(0, 0);
    check_pixels("after_abort", 1);
  endtask

  task automatic test_async_reset;
    int t = 0;
    go(16'd5);
    out_ready = 0;
    while (out_valid !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    vec++;
    if (t >= 200) begin miss++; $display("FAIL areset_reach_stream: out_valid=%b want 1 within 200 cycles", out_valid); end
    #2 reset = 0;
    #1;
    vec++;
    if ({out_valid, read, busy} !== '0) begin miss++; $display("FAIL areset_immediate: valid/read/busy=%b want 0", {out_valid, read, busy}); end
    @(negedge clk);
    reset = 1;
    repeat (5) @(negedge clk);
    vec++;
    if ({busy, erase} !== 2'b00) begin miss++; $display("FAIL areset_stays_idle: busy/erase=%b want 00", {busy, erase}); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_expose;
    test_back_to_back;
    test_abort;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
